debounce_sync: RTL

- Input-conditioning stage that sits directly upstream of the edge detector.
- Takes a raw asynchronous level (button, external strobe). It double-flop synchronizes the level, then filters glitches with a per-transition stability counter.
- Presents a clean, single-clock-domain level on q. That q drives the edge detector's d input, so rising/falling/toggle fire once per real transition.
- Also counts rejected glitches for debug.

---
 rtl/debounce_sync_pkg.sv | 19 +
 rtl/sync2.sv | 26 ++
 rtl/debounce_sync.sv | 124 ++++++++++++
 3 files changed

// File: rtl/debounce_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_sync_pkg : shared types/constants for input conditioning    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam int DEBOUNCE_MIN = 2;
    localparam int DEBOUNCE_MAX = 65535;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2 : two-flop level synchronizer, async active-low reset to 0     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            q    <= 1'b0;
        end else begin
            r_s1 <= d;
            q    <= r_s1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_sync : synchronize + glitch-filter a raw level, count       |
// |                 rejected transitions. Rev 1.0                        |
// +----------------------------------------------------------------------+
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = $clog2(DEBOUNCE),
    parameter int GW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d,
    input  logic          glitch_clr,
    output logic          q,
    output logic          pending,
    output logic [GW-1:0] glitch_cnt
);

    generate
        if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_debounce
            $error("debounce_sync: DEBOUNCE out of range 2..65535");
        end
        if (CNT_W != $clog2(DEBOUNCE)) begin : g_bad_cnt_w
            $error("debounce_sync: CNT_W is derived and must not be overridden");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [GW-1:0]    c_GC_MAX   = '1;

    logic             w_s;
    logic             w_glitch;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (w_s)
    );

    // A candidate is rejected the moment the synchronized level reverts.
    assign w_glitch = ((r_state == PEND_HI) && !w_s) || ((r_state == PEND_LO) && w_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            q       <= 1'b0;
            pending <= 1'b0;
        end else begin
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= PEND_HI;
                        r_cnt   <= CNT_W'(1);
                        pending <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PEND_HI: begin
                    if (!w_s) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        pending <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        q       <= 1'b1;
                        pending <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= PEND_LO;
                        r_cnt   <= CNT_W'(1);
                        pending <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PEND_LO: begin
                    if (w_s) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        pending <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        q       <= 1'b0;
                        pending <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    q       <= 1'b0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (w_glitch && (glitch_cnt != c_GC_MAX)) begin
            glitch_cnt <= glitch_cnt + GW'(1);
        end
    end

endmodule
`default_nettype wire
